// File: rtl/wire_ep_pkg.sv
// Shared definitions for the FPGA-internal wire endpoint bus.
// Contents: command op encodings, initiator FSM state encoding, wire count,
// bus widths, and the address-window helpers used for legality checks.
package wire_ep_pkg;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 32;
   localparam int WIRE_COUNT = 32;

   typedef enum logic [1:0] {
      OP_WRITE      = 2'd0,
      OP_READ       = 2'd1,
      OP_UPDATE_IN  = 2'd2,
      OP_UPDATE_OUT = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   // True when addr lies in base..base+WIRE_COUNT-1 (modulo address space).
   function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base);
      logic [ADDR_W-1:0] off;
      off = addr - base;
      return off < ADDR_W'(WIRE_COUNT);
   endfunction

   // WRITE targets WireIns only, READ targets WireOuts only, updates always legal.
   function automatic logic cmd_legal(input op_e               op,
                                      input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] in_base,
                                      input logic [ADDR_W-1:0] out_base);
      logic ok;
      case (op)
         OP_WRITE: ok = in_window(addr, in_base);
         OP_READ:  ok = in_window(addr, out_base);
         default:  ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/wire_host_initiator.sv
// Initiator for the wire endpoint bus. Accepts one host command at a time,
// issues a single one-cycle endpoint strobe (ep_wr, ep_rd, ep_update_in or
// ep_update_out) and returns exactly one response per command.
//
// Ports:
//   okClk, reset              clock, synchronous active-high reset
//   cmd_valid/ready/op/addr/data  command channel
//   rsp_valid/ready/data/err      response channel
//   ep_wr/ep_rd/ep_addr/ep_wdata  endpoint access strobes and payload
//   ep_rdata                      OR-combined WireOut read data
//   ep_update_in/ep_update_out    endpoint commit/capture pulses
//   dbg_state                     current FSM state (state_e encoding)
//
// Handshake: both channels use valid/ready. A transfer happens on the rising
// edge where valid and ready are both 1; valid never depends on ready, and
// the response payload is held stable while rsp_valid=1 and rsp_ready=0.
module wire_host_initiator
   import wire_ep_pkg::*;
#(
   parameter int         RD_LATENCY = 1,
   parameter logic [7:0] IN_BASE    = 8'h00,
   parameter logic [7:0] OUT_BASE   = 8'h20
) (
   input  logic        okClk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_addr,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        ep_wr,
   output logic        ep_rd,
   output logic [7:0]  ep_addr,
   output logic [31:0] ep_wdata,
   input  logic [31:0] ep_rdata,
   output logic        ep_update_in,
   output logic        ep_update_out,
   output logic [1:0]  dbg_state
);

   // The counter runs from RD_LATENCY-1 down to 0 while in WAIT_RD, so the
   // sample lands RD_LATENCY cycles after the ep_rd cycle.
   localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        wr_q, wr_d;
   logic        rd_q, rd_d;
   logic        upd_in_q, upd_in_d;
   logic        upd_out_q, upd_out_d;
   op_e         cmd_op_e;
   logic        legal;

   assign cmd_op_e = op_e'(cmd_op);
   // Evaluated on the value being registered this edge, so it matches the
   // registered address that the strobe will carry.
   assign legal    = cmd_legal(cmd_op_e, cmd_addr, IN_BASE, OUT_BASE);

   always_ff @(posedge okClk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_WRITE;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         upd_in_q    <= 1'b0;
         upd_out_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_valid_q <= rsp_valid_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         upd_in_q    <= upd_in_d;
         upd_out_q   <= upd_out_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      rsp_valid_d = rsp_valid_q;
      // Strobes default low so each lasts exactly one cycle.
      wr_d        = 1'b0;
      rd_d        = 1'b0;
      upd_in_d    = 1'b0;
      upd_out_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d       = cmd_op_e;
               addr_d     = cmd_addr;
               wdata_d    = cmd_data;
               rsp_data_d = '0;
               if (legal) begin
                  rsp_err_d = 1'b0;
                  state_d   = ST_ISSUE;
                  wr_d      = (cmd_op_e == OP_WRITE);
                  rd_d      = (cmd_op_e == OP_READ);
                  upd_in_d  = (cmd_op_e == OP_UPDATE_IN);
                  upd_out_d = (cmd_op_e == OP_UPDATE_OUT);
               end else begin
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end
            end
         end
         ST_ISSUE: begin
            if (op_q == OP_READ) begin
               cnt_d   = RD_LOAD;
               state_d = ST_WAIT_RD;
            end else begin
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_WAIT_RD: begin
            if (cnt_q == 4'd0) begin
               rsp_data_d  = ep_rdata;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Held low during the reset cycle so no command can slip in as reset lifts.
   assign cmd_ready     = (state_q == ST_IDLE) && !reset;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_err       = rsp_err_q;
   assign ep_wr         = wr_q;
   assign ep_rd         = rd_q;
   assign ep_addr       = addr_q;
   assign ep_wdata      = wdata_q;
   assign ep_update_in  = upd_in_q;
   assign ep_update_out = upd_out_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_wire_host_initiator.sv
module tb_wire_host_initiator;
  import wire_ep_pkg::*;

  localparam int RD_LAT = 3;

  // ---------------- clock / reset ----------------
  logic        okClk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ep_wr, ep_rd, ep_update_in, ep_update_out;
  logic [7:0]  ep_addr;
  logic [31:0] ep_wdata;
  logic [31:0] ep_rdata;
  logic [1:0]  dbg_state;

  always #5 okClk = ~okClk;

  wire_host_initiator #(
    .RD_LATENCY(RD_LAT),
    .IN_BASE   (8'h00),
    .OUT_BASE  (8'h20)
  ) dut (
    .okClk        (okClk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .ep_wr        (ep_wr),
    .ep_rd        (ep_rd),
    .ep_addr      (ep_addr),
    .ep_wdata     (ep_wdata),
    .ep_rdata     (ep_rdata),
    .ep_update_in (ep_update_in),
    .ep_update_out(ep_update_out),
    .dbg_state    (dbg_state)
  );

  // ---------------- endpoint model ----------------
  // WireIn shadow/commit registers and WireOuts that capture an adder:
  // wo[i] = win_out[i] + win_out[i+1]. wo[1] powers up as 7.
  logic [31:0] shadow [32];
  logic [31:0] win_out[32];
  logic [31:0] wo     [32];
  logic        rd_pipe     [RD_LAT];
  logic [7:0]  rd_addr_pipe[RD_LAT];

  always @(posedge okClk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        shadow[i]  <= 32'h0;
        win_out[i] <= 32'h0;
        wo[i]      <= (i == 1) ? 32'd7 : 32'd0;
      end
      for (int i = 0; i < RD_LAT; i++) begin
        rd_pipe[i]      <= 1'b0;
        rd_addr_pipe[i] <= 8'h00;
      end
    end else begin
      if (ep_wr) shadow[ep_addr[4:0]] <= ep_wdata;
      if (ep_update_in)
        for (int i = 0; i < 32; i++) win_out[i] <= shadow[i];
      if (ep_update_out)
        for (int i = 0; i < 32; i++) wo[i] <= win_out[i] + win_out[(i + 1) % 32];
      rd_pipe[0]      <= ep_rd;
      rd_addr_pipe[0] <= ep_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i]      <= rd_pipe[i-1];
        rd_addr_pipe[i] <= rd_addr_pipe[i-1];
      end
    end
  end

  assign ep_rdata = rd_pipe[RD_LAT-1] ? wo[rd_addr_pipe[RD_LAT-1][4:0]] : 32'h0;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  logic [32:0] exp_item;
  int          strobe_seen = 0;
  int          strobe_exp  = 0;
  time         acc_t;

  always @(negedge okClk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'({rsp_err, rsp_data}), 64'h1_0000_0000_0000);
      end else begin
        exp_item = exp_q.pop_front();
        check("rsp", 64'({rsp_err, rsp_data}), 64'(exp_item));
      end
    end
    if (ep_wr || ep_rd || ep_update_in || ep_update_out) strobe_seen++;
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at the negedge where rsp_valid is first seen.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] data,
                        input logic exp_err, input logic [31:0] exp_data);
    int   n;
    int   lat;
    bit   got;
    logic [3:0] exp_vec;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    n   = 0;
    got = 0;
    while (!got && n < 50) begin
      @(negedge okClk);
      if (cmd_ready) got = 1;
      n++;
      @(posedge okClk);
    end
    acc_t = $time;
    #1 cmd_valid = 1'b0;
    if (!got) begin
      check("accept_timeout", 64'(got), 64'd1);
      return;
    end
    exp_q.push_back({exp_err, exp_data});
    // cycle 1
    @(negedge okClk);
    exp_vec = exp_err ? 4'b0000 : (4'b1000 >> op);
    check("strobe", 64'({ep_wr, ep_rd, ep_update_in, ep_update_out}), 64'(exp_vec));
    if (!exp_err) begin
      strobe_exp++;
      if (op == OP_WRITE || op == OP_READ) check("ep_addr", 64'(ep_addr), 64'(addr));
      if (op == OP_WRITE) check("ep_wdata", 64'(ep_wdata), 64'(data));
    end
    lat = exp_err ? 1 : ((op == OP_READ) ? 2 + RD_LAT : 2);
    n = 1;
    while (!rsp_valid && n < 60) begin
      @(negedge okClk);
      n++;
    end
    check("rsp_latency", 64'(n), 64'(lat));
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] data,
                         input logic exp_err, input logic [31:0] exp_data);
    do_cmd(op, addr, data, exp_err, exp_data);
    @(posedge okClk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  time t_a;

  initial begin
    // reset
    repeat (3) @(posedge okClk);
    @(negedge okClk);
    check("cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
    @(posedge okClk);
    #1 reset = 1'b0;
    @(negedge okClk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp", 64'({rsp_err, rsp_data}), 64'd0);
    check("rst_ep_addr", 64'(ep_addr), 64'd0);
    check("rst_ep_wdata", 64'(ep_wdata), 64'd0);
    check("rst_strobes", 64'({ep_wr, ep_rd, ep_update_in, ep_update_out}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge okClk);
    #1;

    // single write, single read, illegal ops
    run_cmd(OP_WRITE, 8'h01, 32'hDEADBEEF, 1'b0, 32'h0);
    run_cmd(OP_READ,  8'h21, 32'h0,        1'b0, 32'h7);
    run_cmd(OP_WRITE, 8'h20, 32'h1111_2222, 1'b1, 32'h0);
    run_cmd(OP_READ,  8'h05, 32'h0,        1'b1, 32'h0);
    run_cmd(OP_WRITE, 8'h1F, 32'hCAFE_0001, 1'b0, 32'h0);
    run_cmd(OP_READ,  8'h40, 32'h0,        1'b1, 32'h0);

    // loopback with back-to-back throughput check
    run_cmd(OP_WRITE, 8'h01, 32'd5, 1'b0, 32'h0);
    t_a = acc_t;
    run_cmd(OP_WRITE, 8'h02, 32'd9, 1'b0, 32'h0);
    check("b2b_gap", 64'(acc_t - t_a), 64'd30);
    run_cmd(OP_UPDATE_IN,  8'h00, 32'h0, 1'b0, 32'h0);
    run_cmd(OP_UPDATE_OUT, 8'h00, 32'h0, 1'b0, 32'h0);
    run_cmd(OP_READ, 8'h21, 32'h0, 1'b0, 32'd14);

    // backpressure
    rsp_ready = 1'b0;
    do_cmd(OP_READ, 8'h21, 32'h0, 1'b0, 32'd14);
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_data", 64'(rsp_data), 64'd14);
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge okClk);
    end
    @(posedge okClk);
    #1 rsp_ready = 1'b1;
    @(posedge okClk);
    #1;

    // reset during WAIT_RD
    cmd_valid = 1'b1;
    cmd_op    = OP_READ;
    cmd_addr  = 8'h21;
    @(negedge okClk);
    check("mr_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge okClk);
    #1 cmd_valid = 1'b0;
    @(negedge okClk);
    check("mr_ep_rd", 64'(ep_rd), 64'd1);
    strobe_exp++;
    @(posedge okClk);
    #1 reset = 1'b1;
    @(negedge okClk);
    check("mr_state_wait", 64'(dbg_state), 64'(ST_WAIT_RD));
    check("mr_ready_in_reset", 64'(cmd_ready), 64'd0);
    @(posedge okClk);
    #1 reset = 1'b0;
    @(negedge okClk);
    check("mr_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("mr_cmd_ready_after", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      check("mr_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge okClk);
    end
    @(posedge okClk);
    #1;
    run_cmd(OP_WRITE, 8'h03, 32'h1234_5678, 1'b0, 32'h0);

    // random mix
    for (int k = 0; k < 12; k++) begin
      logic [1:0]  r_op;
      logic [7:0]  r_addr;
      logic [31:0] r_data;
      logic        r_err;
      logic [31:0] r_exp;
      r_op   = 2'($urandom_range(0, 3));
      r_addr = 8'($urandom_range(0, 79));
      r_data = $urandom;
      r_err  = 1'b0;
      r_exp  = 32'h0;
      if (r_op == OP_WRITE) r_err = !(r_addr < 8'h20);
      if (r_op == OP_READ) begin
        r_err = !(r_addr >= 8'h20 && r_addr < 8'h40);
        if (!r_err) r_exp = wo[r_addr[4:0]];
      end
      run_cmd(r_op, r_addr, r_data, r_err, r_exp);
    end

    repeat (4) @(posedge okClk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("strobe_count", 64'(strobe_seen), 64'(strobe_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
